// File: rtl/pe_relay_pkg.sv
// -----------------------------------------------------------------------------
// pe_relay_pkg
//   Shared constants for the pass-through PE tile:
//   - default tile geometry (word width, channel count, FIFO depth)
//   - channel index names (east = 0, south = 1)
//   - an elaboration-time helper for validating the FIFO depth
// -----------------------------------------------------------------------------
package pe_relay_pkg;

  localparam int DATA_WIDTH_DEF = 130;
  localparam int NUM_CH_DEF     = 2;
  localparam int DEPTH_DEF      = 4;

  localparam int CH_EAST  = 0;
  localparam int CH_SOUTH = 1;

  // True when v is a positive power of two.
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage : pe_relay_pkg

// File: rtl/pe_relay_fifo.sv
// -----------------------------------------------------------------------------
// pe_relay_fifo
//   Single-channel elastic FIFO used by each pe_relay channel.
//   Full/empty are derived from the occupancy counter, so the pointers only
//   need log2(DEPTH) bits and wrap naturally.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         synchronous clear of pointers and count (storage kept)
//   push_data_i     word to enqueue
//   push_valid_i    upstream valid
//   push_ready_o    upstream ready (not full and not flushing)
//   pop_i           dequeue request; ignored while empty or flushing
//   head_o          entry at the read pointer, read from registered storage
//   not_empty_o     at least one entry stored
//   count_o         number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module pe_relay_fifo
  import pe_relay_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  not_empty_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;

  logic full;
  logic do_push;
  logic do_pop;

  assign full        = (count_q == FULL_CNT);
  assign not_empty_o = (count_q != '0);
  assign count_o     = count_q;
  assign head_o      = mem_q[rd_ptr_q];

  // No full-bypass: a pop in the same cycle does not reopen a full FIFO,
  // which keeps push_ready_o free of any path from the downstream side.
  assign push_ready_o = !full && !flush_i;
  assign do_push      = push_valid_i && push_ready_o;
  assign do_pop       = pop_i && not_empty_o && !flush_i;

  // NOTE: every variable gets its hold value first, so no path through this
  // block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is reset because the tile must present all-zero data out of
  // reset; this keeps it in flops rather than a RAM macro, which suits the
  // small depths this tile is built with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule : pe_relay_fifo

// File: rtl/pe_relay.sv
// -----------------------------------------------------------------------------
// pe_relay
//   Pass-through processing-element tile that fills an empty PE slot. Carries
//   NUM_CH independent channels (channel 0 = east, channel 1 = south by
//   default) across the tile, each through its own DEPTH-entry FIFO.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   ap_start   output enable; while low no channel presents data
//   flush      synchronous clear of all FIFOs (contents kept, pointers zeroed)
//   in_data    channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   per-channel upstream valid
//   in_ready   per-channel upstream ready
//   out_data   per-channel head word (shown even while ap_start is low)
//   out_valid  per-channel downstream valid
//   out_ready  per-channel downstream ready
//   occupancy  per-channel entry count at [c*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module pe_relay
  import pe_relay_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int NUM_CH     = NUM_CH_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ap_start,
  input  logic                         flush,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic [NUM_CH*CNT_W-1:0]      occupancy
);

  // A depth below two cannot stream at full rate because in_ready drops at
  // full; a non-power-of-two depth would break the natural pointer wrap.
  if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
    $error("pe_relay: DEPTH=%0d must be a power of two and >= 2", DEPTH);
  end

  logic [NUM_CH-1:0] not_empty;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pe_relay_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (reset),
      .flush_i      (flush),
      .push_data_i  (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .push_valid_i (in_valid[c]),
      .push_ready_o (in_ready[c]),
      .pop_i        (out_valid[c] && out_ready[c]),
      .head_o       (out_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .not_empty_o  (not_empty[c]),
      .count_o      (occupancy[c*CNT_W +: CNT_W])
    );

    // Gating only valid (not the pop path inside the FIFO) holds data in
    // place while ap_start is low and keeps the head word visible.
    assign out_valid[c] = not_empty[c] && ap_start;
  end

endmodule : pe_relay

// File: tb/tb_pe_relay.sv
// -----------------------------------------------------------------------------
// tb_pe_relay
//   Self-checking bench for pe_relay in its default configuration
//   (DATA_WIDTH = 130, NUM_CH = 2, DEPTH = 4).
// -----------------------------------------------------------------------------
module tb_pe_relay;

  localparam int DW  = 130;
  localparam int NCH = 2;
  localparam int CW  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ap_start;
  logic              flush;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*CW-1:0] occupancy;

  int checks   = 0;
  int failures = 0;

  pe_relay dut (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data(input int c, input logic [DW-1:0] v);
    in_data[c*DW +: DW] = v;
  endtask

  function automatic logic [DW-1:0] q(input int c);
    return out_data[c*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] occ(input int c);
    return occupancy[c*CW +: CW];
  endfunction

  // One table row = inputs held for one cycle plus the outputs expected just
  // before the following rising edge. Channel 1 stays idle throughout.
  typedef struct {
    logic        ap;
    logic        fl;
    logic [1:0]  iv;
    logic [1:0]  ordy;
    logic [15:0] d0;
    logic [1:0]  e_ir;
    logic [1:0]  e_ov;
    logic [15:0] e_q0;
    logic [2:0]  e_occ0;
  } vec_t;

  vec_t vecs[17];

  initial begin
    //            ap    fl    iv     or     d0      ir     ov     q0      occ0
    // fill with ap_start low, then full + pop + push in the same cycle
    vecs[0]  = '{1'b0, 1'b0, 2'b01, 2'b00, 16'h1, 2'b11, 2'b00, 16'h0, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 2'b01, 2'b00, 16'h2, 2'b11, 2'b00, 16'h1, 3'd1};
    vecs[2]  = '{1'b0, 1'b0, 2'b01, 2'b00, 16'h3, 2'b11, 2'b00, 16'h1, 3'd2};
    vecs[3]  = '{1'b0, 1'b0, 2'b01, 2'b00, 16'h4, 2'b11, 2'b00, 16'h1, 3'd3};
    vecs[4]  = '{1'b0, 1'b0, 2'b01, 2'b00, 16'h5, 2'b10, 2'b00, 16'h1, 3'd4};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, 2'b01, 16'h5, 2'b10, 2'b01, 16'h1, 3'd4};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 2'b01, 16'h5, 2'b11, 2'b01, 16'h2, 3'd3};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 2'b01, 16'h0, 2'b11, 2'b01, 16'h3, 3'd3};
    vecs[8]  = '{1'b1, 1'b0, 2'b00, 2'b01, 16'h0, 2'b11, 2'b01, 16'h4, 3'd2};
    vecs[9]  = '{1'b1, 1'b0, 2'b00, 2'b01, 16'h0, 2'b11, 2'b01, 16'h5, 3'd1};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 2'b01, 16'h0, 2'b11, 2'b00, 16'h2, 3'd0};
    // two words queued, flush with in_valid high, then push 0xA
    vecs[11] = '{1'b1, 1'b0, 2'b01, 2'b00, 16'h6, 2'b11, 2'b00, 16'h2, 3'd0};
    vecs[12] = '{1'b1, 1'b0, 2'b01, 2'b00, 16'h7, 2'b11, 2'b01, 16'h6, 3'd1};
    vecs[13] = '{1'b1, 1'b1, 2'b01, 2'b01, 16'h8, 2'b00, 2'b01, 16'h6, 3'd2};
    vecs[14] = '{1'b1, 1'b0, 2'b01, 2'b01, 16'hA, 2'b11, 2'b00, 16'h5, 3'd0};
    vecs[15] = '{1'b1, 1'b0, 2'b00, 2'b01, 16'h0, 2'b11, 2'b01, 16'hA, 3'd1};
    vecs[16] = '{1'b1, 1'b0, 2'b00, 2'b01, 16'h0, 2'b11, 2'b00, 16'h6, 3'd0};

    reset     = 1'b0;
    ap_start  = 1'b0;
    flush     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = '0;

    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // ---- asynchronous reset with 3 words queued on channel 0 ----
    ap_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 2'b01;
      set_data(0, DW'(8'h11 * (i + 1)));
    end
    @(negedge clk);
    in_valid = 2'b00;
    #1;
    check("pre-reset out_valid", 256'(out_valid), 256'(2'b01));
    check("pre-reset occupancy0", 256'(occ(0)), 256'(3));
    check("pre-reset out_data0", 256'(q(0)), 256'(8'h11));
    #2;
    reset = 1'b0;
    #1;
    check("async reset out_valid", 256'(out_valid), 256'(2'b00));
    check("async reset occupancy0", 256'(occ(0)), 256'(0));
    check("async reset out_data0", 256'(q(0)), 256'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("after reset in_ready", 256'(in_ready), 256'(2'b11));

    // ---- table-driven vectors on channel 0 ----
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      ap_start  = vecs[i].ap;
      flush     = vecs[i].fl;
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      set_data(0, DW'(vecs[i].d0));
      #1;
      check($sformatf("v%0d in_ready", i), 256'(in_ready), 256'(vecs[i].e_ir));
      check($sformatf("v%0d out_valid", i), 256'(out_valid), 256'(vecs[i].e_ov));
      check($sformatf("v%0d out_data0", i), 256'(q(0)), 256'(vecs[i].e_q0));
      check($sformatf("v%0d occupancy0", i), 256'(occ(0)), 256'(vecs[i].e_occ0));
    end

    // ---- streaming 10 words on channel 1, pointers wrap twice ----
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      ap_start  = 1'b1;
      flush     = 1'b0;
      out_ready = 2'b10;
      in_valid  = (i < 10) ? 2'b10 : 2'b00;
      set_data(1, DW'(16'h100 + i));
      #1;
      if (i == 0) begin
        check("stream first out_valid1", 256'(out_valid[1]), 256'(0));
        check("stream first occupancy1", 256'(occ(1)), 256'(0));
      end else begin
        check($sformatf("stream%0d out_valid1", i), 256'(out_valid[1]), 256'(1));
        check($sformatf("stream%0d out_data1", i), 256'(q(1)), 256'(16'h100 + i - 1));
        check($sformatf("stream%0d occupancy1", i), 256'(occ(1)), 256'(1));
      end
    end
    @(negedge clk);
    in_valid = 2'b00;
    #1;
    check("stream end out_valid1", 256'(out_valid[1]), 256'(0));
    check("stream end occupancy1", 256'(occ(1)), 256'(0));

    // ---- channel independence: ch1 stalls and fills, ch0 streams ----
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ap_start  = 1'b1;
      out_ready = 2'b01;
      in_valid  = 2'b11;
      set_data(0, DW'(16'h200 + i));
      set_data(1, DW'(16'h300 + i));
      #1;
      check($sformatf("indep%0d in_ready0", i), 256'(in_ready[0]), 256'(1));
      check($sformatf("indep%0d in_ready1", i), 256'(in_ready[1]), 256'(i < 4));
      check($sformatf("indep%0d occupancy1", i), 256'(occ(1)), 256'((i < 4) ? i : 4));
      if (i > 0) begin
        check($sformatf("indep%0d out_valid0", i), 256'(out_valid[0]), 256'(1));
        check($sformatf("indep%0d out_data0", i), 256'(q(0)), 256'(16'h200 + i - 1));
      end
    end
    @(negedge clk);
    in_valid  = 2'b00;
    out_ready = 2'b11;
    #1;
    check("indep ch1 head", 256'(q(1)), 256'(16'h300));
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    check("drained occupancy", 256'(occupancy), 256'(0));
    check("drained out_valid", 256'(out_valid), 256'(2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pe_relay
